// File: rtl/game_pkg.sv
// Shared game-wide constants and types.
// Layer indices follow the drawer priority order.
package game_pkg;

  localparam int RGB_W = 8;
  localparam int NUM_LAYERS = 4;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t TRANSPARENT_ENCODING = 8'h00;

  localparam int SCORE_HDR_IDX = 0;
  localparam int PLAYER_IDX = 1;
  localparam int ENEMY_IDX = 2;
  localparam int FUEL_IDX = 3;

  localparam logic [NUM_LAYERS-1:0] COLLIDE_MASK = 4'b1100;

endpackage

// File: rtl/objects_mux_collision_if.sv
// Drawing-request bus: one DR/RGB pair per layer
// plus the background colour.
interface objects_mux_collision_if
  import game_pkg::*;
#(
  parameter int N = NUM_LAYERS
);

  logic [N-1:0] layerDR;
  logic [N-1:0][RGB_W-1:0] layerRGB;
  rgb_t backGroundRGB;

  modport master (
    output layerDR,
    output layerRGB,
    output backGroundRGB
  );

  modport slave (
    input layerDR,
    input layerRGB,
    input backGroundRGB
  );

endinterface

// File: rtl/collision_tracker.sv
// Player-vs-layer overlap detection with one pulse
// per layer per frame and a saturating hit-frame count.
module collision_tracker
  import game_pkg::*;
#(
  parameter int N = NUM_LAYERS,
  parameter int PIDX = PLAYER_IDX,
  parameter logic [N-1:0] MASK = COLLIDE_MASK
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic [N-1:0] layerDR,
  output logic [N-1:0] collisionPulse,
  output logic         collisionAny,
  output logic [7:0]   hitFrames
);

  logic [N-1:0] hit;
  logic [N-1:0] eff_flags;
  logic [N-1:0] new_hit;
  logic [N-1:0] frame_flags;
  logic         frame_had_hit;
  logic         any_hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      if (i != PIDX) begin
        hit[i] = layerDR[PIDX] & layerDR[i] & MASK[i];
      end
    end
  end

  // Frame start clears the flags before this cycle's
  // hit is considered, so a first-pixel hit still pulses.
  assign eff_flags = startOfFrame ? '0 : frame_flags;
  assign new_hit = hit & ~eff_flags;
  assign any_hit = |hit;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      collisionPulse <= '0;
      collisionAny <= 1'b0;
      frame_flags <= '0;
      frame_had_hit <= 1'b0;
      hitFrames <= 8'h00;
    end else begin
      collisionPulse <= new_hit;
      collisionAny <= |new_hit;
      frame_flags <= eff_flags | hit;
      if (startOfFrame) begin
        if (frame_had_hit && hitFrames != 8'hFF) begin
          hitFrames <= hitFrames + 8'd1;
        end
        frame_had_hit <= any_hit;
      end else begin
        frame_had_hit <= frame_had_hit | any_hit;
      end
    end
  end

endmodule

// File: rtl/objects_mux_collision.sv
// Final pixel priority mux toward VGA plus
// player collision tracking.
module objects_mux_collision
  import game_pkg::*;
#(
  parameter int NUM_LAYERS = game_pkg::NUM_LAYERS,
  parameter int PLAYER_IDX = game_pkg::PLAYER_IDX,
  parameter logic [NUM_LAYERS-1:0] COLLIDE_MASK =
    game_pkg::COLLIDE_MASK
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  objects_mux_collision_if.slave bus,
  output rgb_t                  RGBOut,
  output logic [NUM_LAYERS-1:0] collisionPulse,
  output logic                  collisionAny,
  output logic [7:0]            hitFrames
);

  rgb_t pix;

  // Walk from lowest priority up so index 0 wins last.
  // RGB is never inspected: DR already carries transparency.
  always_comb begin
    pix = bus.backGroundRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layerDR[i]) begin
        pix = bus.layerRGB[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      RGBOut <= 8'h00;
    end else begin
      RGBOut <= pix;
    end
  end

  collision_tracker #(
    .N    (NUM_LAYERS),
    .PIDX (PLAYER_IDX),
    .MASK (COLLIDE_MASK)
  ) u_tracker (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .layerDR        (bus.layerDR),
    .collisionPulse (collisionPulse),
    .collisionAny   (collisionAny),
    .hitFrames      (hitFrames)
  );

endmodule

// File: tb/tb_objects_mux_collision.sv
// Directed plus randomized checks of the pixel mux
// and collision tracker against a frame-level model.
module tb_objects_mux_collision;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  rgb_t       RGBOut;
  logic [3:0] collisionPulse;
  logic       collisionAny;
  logic [7:0] hitFrames;

  objects_mux_collision_if bus ();

  objects_mux_collision dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .bus            (bus),
    .RGBOut         (RGBOut),
    .collisionPulse (collisionPulse),
    .collisionAny   (collisionAny),
    .hitFrames      (hitFrames)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  bit   reported [4];
  bit   frame_hit;
  int   frames;
  rgb_t m_rgb;
  bit [3:0] m_pulse;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) reported[i] = 0;
    frame_hit = 0;
    frames = 0;
    m_rgb = 8'h00;
    m_pulse = 4'h0;
  endtask

  task automatic step(input bit rn,
                      input bit [3:0] dr,
                      input bit [31:0] rgb,
                      input bit [7:0] bg,
                      input bit sof);
    bit found;
    resetN = rn;
    startOfFrame = sof;
    bus.layerDR = dr;
    bus.layerRGB = rgb;
    bus.backGroundRGB = bg;
    if (!rn) begin
      model_reset();
    end else begin
      if (sof) begin
        if (frame_hit && frames < 255) frames++;
        frame_hit = 0;
        for (int i = 0; i < 4; i++) reported[i] = 0;
      end
      m_pulse = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (i != 1 && COLLIDE_MASK[i] && dr[1] && dr[i]) begin
          frame_hit = 1;
          if (!reported[i]) m_pulse[i] = 1'b1;
          reported[i] = 1;
        end
      end
      found = 0;
      m_rgb = bg;
      for (int i = 0; i < 4; i++) begin
        if (!found && dr[i]) begin
          m_rgb = rgb[i*8 +: 8];
          found = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rgb", {24'h0, RGBOut}, {24'h0, m_rgb});
    chk("pulse", {28'h0, collisionPulse}, {28'h0, m_pulse});
    chk("any", {31'h0, collisionAny}, {31'h0, |m_pulse});
    chk("frames", {24'h0, hitFrames}, frames);
  endtask

  initial begin
    bit [31:0] rgb_lit;
    model_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0;
    bus.layerDR = '0;
    bus.layerRGB = '0;
    bus.backGroundRGB = '0;

    for (int c = 0; c < 3; c++) begin
      step(0, 4'hF, 32'hA1B2C3D4, 8'h77, 0);
      chk("rst_rgb", {24'h0, RGBOut}, 32'h0);
      chk("rst_pulse", {28'h0, collisionPulse}, 32'h0);
      chk("rst_frames", {24'h0, hitFrames}, 32'h0);
    end

    rgb_lit = 32'hE0_11_6D_22;
    step(1, 4'b1010, rgb_lit, 8'h99, 0);
    chk("prio_rgb", {24'h0, RGBOut}, 32'h6D);
    chk("prio_pulse", {28'h0, collisionPulse}, 32'h8);
    step(1, 4'b0000, rgb_lit, 8'h25, 0);
    chk("bg_rgb", {24'h0, RGBOut}, 32'h25);
    step(1, 4'b0001, 32'h0, 8'h25, 0);
    chk("transp_wins", {24'h0, RGBOut}, 32'h00);

    step(0, 4'h0, 32'h0, 8'h0, 0);
    for (int c = 0; c < 10; c++) begin
      step(1, 4'b0110, 32'h12345678, 8'h40, 0);
      chk("single_pulse", {28'h0, collisionPulse},
          (c == 0) ? 32'h4 : 32'h0);
    end
    step(1, 4'b1010, 32'h12345678, 8'h40, 0);
    chk("l3_pulse", {28'h0, collisionPulse}, 32'h8);
    step(1, 4'b1010, 32'h12345678, 8'h40, 0);
    chk("l3_once", {28'h0, collisionPulse}, 32'h0);
    step(1, 4'b0011, 32'h12345678, 8'h40, 0);
    chk("mask0", {28'h0, collisionPulse}, 32'h0);

    step(1, 4'b0110, 32'h12345678, 8'h40, 1);
    chk("sof_pulse", {28'h0, collisionPulse}, 32'h4);
    chk("sof_frames", {24'h0, hitFrames}, 32'h1);

    step(1, 4'b1110, 32'h0, 8'h0, 0);
    chk("pre_rst", {28'h0, collisionPulse}, 32'h8);
    step(0, 4'b0110, 32'h0, 8'h0, 0);
    step(1, 4'b0110, 32'h0, 8'h0, 0);
    chk("post_rst", {28'h0, collisionPulse}, 32'h4);

    for (int f = 0; f < 300; f++) begin
      step(1, 4'b0000, 32'h0, 8'h01, 1);
      step(1, 4'b1110, 32'h0, 8'h01, 0);
    end
    step(1, 4'b0000, 32'h0, 8'h01, 1);
    chk("saturate", {24'h0, hitFrames}, 32'hFF);

    step(0, 4'h0, 32'h0, 8'h0, 0);
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 299) != 0),
           4'($urandom),
           $urandom,
           8'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
